seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 37 +++
 rtl/seq_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if -- request/result bundle for the sequential signed divider.
//
// Signals
//   start       requester -> divider  one-cycle request pulse
//   dividend    requester -> divider  signed dividend, captured on accept
//   divisor     requester -> divider  signed divisor, captured on accept
//   busy        divider -> requester  operation in progress
//   done        divider -> requester  one-cycle result-valid pulse
//   quotient    divider -> requester  signed quotient (ZLO)
//   remainder   divider -> requester  signed remainder (ZHI)
//   div_by_zero divider -> requester  last completed divide had divisor 0
//
// Modports: master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface : seq_divider_if

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider -- multi-cycle signed integer divider (truncation toward zero).
//
// A request accepted in IDLE captures operand magnitudes and signs, runs
// WIDTH unsigned restoring steps (one per clock) in ITER, then applies the
// signs and publishes the result in FIX together with a one-cycle done.
// Divisor 0 skips ITER: quotient all-ones, remainder = dividend, flag set.
//
// Ports
//   clk  system clock, rising edge
//   clr  asynchronous active-low reset
//   bus  seq_divider_if.slave (start/dividend/divisor in; busy/done/
//        quotient/remainder/div_by_zero out)
//
// WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         clr,
  seq_divider_if.slave bus
);

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t state_q, state_d;

  // Working registers. dvd_q starts as |dividend| and, as its MSBs are
  // shifted into the partial remainder, fills from the bottom with quotient
  // bits, so after WIDTH steps it holds |quotient|. On divide-by-zero it
  // holds the raw dividend instead.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  logic [CNT_W-1:0] cnt_q;

  // Published results
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             done_q;
  logic             dz_out_q;

  // Combinational datapath
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             step_ok;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case so every path assigns it;
  // a missing default in combinational logic infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = (bus.divisor == '0) ? FIX : ITER;
      ITER: if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand magnitudes and one restoring step
  // -------------------------------------------------------------------------
  always_comb begin
    dividend_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    divisor_abs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    // Partial remainder is always < |divisor| <= 2**(WIDTH-1), so the
    // shifted value and the difference both fit in WIDTH+1 bits and the top
    // bit of diff is a reliable borrow.
    rem_shift    = {rem_q, dvd_q[WIDTH-1]};
    diff         = rem_shift - {1'b0, dvs_q};
    step_ok      = ~diff[WIDTH];
  end

  // -------------------------------------------------------------------------
  // Datapath and result registers
  // -------------------------------------------------------------------------
  // NOTE: every register here, results included, is cleared by clr so an
  // aborted operation leaves no stale quotient, remainder or flag visible.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              dvd_q <= bus.dividend;
              dz_q  <= 1'b1;
            end else begin
              dvd_q   <= dividend_abs;
              dvs_q   <= divisor_abs;
              q_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_neg_q <= bus.dividend[WIDTH-1];
              rem_q   <= '0;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
            end
          end
        end

        ITER: begin
          rem_q <= step_ok ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], step_ok};
          cnt_q <= cnt_q + CNT_W'(1);
        end

        FIX: begin
          done_q   <= 1'b1;
          dz_out_q <= dz_q;
          if (dz_q) begin
            quo_out_q <= '1;
            rem_out_q <= dvd_q;
          end else begin
            // Most-negative / -1 lands here with |q| = 2**(WIDTH-1) and no
            // negation, which reads back as the most-negative value.
            quo_out_q <= q_neg_q ? -dvd_q : dvd_q;
            rem_out_q <= r_neg_q ? -rem_q : rem_q;
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quo_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dz_out_q;

endmodule : seq_divider
